// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Decodes a binary spike train back into numbers. Two independent
//   measurements are produced:
//     - a windowed spike-rate count over a programmable number of cycles,
//       reported once per window by a small IDLE/ACCUM/REPORT FSM;
//     - an inter-spike-interval (ISI) measurement that runs continuously.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   en_i         : run enable; windows start and continue only while high
//   spike_i      : spike train, sampled on every rising edge
//   window_i     : window length in cycles (0 means 2^WIDTH), latched at
//                  window start only
//   rate_o       : spike count of the last completed window
//   rate_valid_o : one-cycle pulse when rate_o has just been updated
//   sat_o        : spike count saturated in the window reported on rate_o
//   isi_o        : cycles between the last two spikes (saturating)
//   isi_valid_o  : one-cycle pulse when isi_o has just been updated
//   busy_o       : rate FSM is not idle
module spike_rate_decoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             spike_i,
  input  logic [WIDTH-1:0] window_i,
  output logic [WIDTH-1:0] rate_o,
  output logic             rate_valid_o,
  output logic             sat_o,
  output logic [WIDTH-1:0] isi_o,
  output logic             isi_valid_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH:0]   WIN_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   WIN_FULL = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  state_t state;
  state_t state_next;

  // Window length and window counter are one bit wider than WIDTH so a
  // window of exactly 2^WIDTH cycles can be represented and reached.
  logic [WIDTH:0]   win_len;
  logic [WIDTH:0]   win_len_next;
  logic [WIDTH:0]   win_cnt;
  logic [WIDTH:0]   win_cnt_next;
  logic [WIDTH:0]   win_cnt_inc;

  logic [WIDTH-1:0] spk_cnt;
  logic [WIDTH-1:0] spk_cnt_next;
  logic [WIDTH-1:0] spk_cnt_acc;
  logic             sat_flag;
  logic             sat_flag_next;
  logic             sat_flag_acc;

  logic [WIDTH-1:0] rate_next;
  logic             sat_next;
  logic             rate_valid_next;

  // ISI tracker state
  logic [WIDTH-1:0] gap;
  logic             seen;

  // ---------------------------------------------------------------------
  // Rate FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Rate FSM: next state and datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    win_len_next    = win_len;
    win_cnt_next    = win_cnt;
    spk_cnt_next    = spk_cnt;
    sat_flag_next   = sat_flag;
    rate_next       = rate_o;
    sat_next        = sat_o;
    rate_valid_next = 1'b0;

    win_cnt_inc  = win_cnt + WIN_ONE;

    // Count including this edge's spike; a spike arriving at the ceiling
    // is recorded as saturation instead of wrapping the counter.
    spk_cnt_acc  = spk_cnt;
    sat_flag_acc = sat_flag;
    if (spike_i) begin
      if (spk_cnt == CNT_MAX) begin
        sat_flag_acc = 1'b1;
      end else begin
        spk_cnt_acc = spk_cnt + CNT_ONE;
      end
    end

    case (state)
      // IDLE and REPORT leave identically: start a new window if enabled,
      // otherwise rest in IDLE. REPORT's spike is never accumulated.
      IDLE, REPORT: begin
        win_cnt_next  = '0;
        spk_cnt_next  = '0;
        sat_flag_next = 1'b0;
        if (en_i) begin
          win_len_next = (window_i == '0) ? WIN_FULL : {1'b0, window_i};
          state_next   = ACCUM;
        end else begin
          state_next   = IDLE;
        end
      end

      ACCUM: begin
        if (!en_i) begin
          // Abort: discard the window, keep the previous report.
          state_next    = IDLE;
          win_cnt_next  = '0;
          spk_cnt_next  = '0;
          sat_flag_next = 1'b0;
        end else if (win_cnt_inc == win_len) begin
          rate_next       = spk_cnt_acc;
          sat_next        = sat_flag_acc;
          rate_valid_next = 1'b1;
          state_next      = REPORT;
          win_cnt_next    = '0;
          spk_cnt_next    = '0;
          sat_flag_next   = 1'b0;
        end else begin
          win_cnt_next  = win_cnt_inc;
          spk_cnt_next  = spk_cnt_acc;
          sat_flag_next = sat_flag_acc;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_len      <= '0;
      win_cnt      <= '0;
      spk_cnt      <= '0;
      sat_flag     <= 1'b0;
      rate_o       <= '0;
      sat_o        <= 1'b0;
      rate_valid_o <= 1'b0;
    end else begin
      win_len      <= win_len_next;
      win_cnt      <= win_cnt_next;
      spk_cnt      <= spk_cnt_next;
      sat_flag     <= sat_flag_next;
      rate_o       <= rate_next;
      sat_o        <= sat_next;
      rate_valid_o <= rate_valid_next;
    end
  end

  assign busy_o = (state != IDLE);

  // ---------------------------------------------------------------------
  // ISI tracker: independent of the FSM and of en_i.
  // gap counts cycles since the last spike, starting at 1 on the edge
  // after the spike, so back-to-back spikes report an interval of 1.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap         <= '0;
      seen        <= 1'b0;
      isi_o       <= '0;
      isi_valid_o <= 1'b0;
    end else begin
      if (spike_i) begin
        gap  <= CNT_ONE;
        seen <= 1'b1;
        if (seen) begin
          isi_o       <= gap;
          isi_valid_o <= 1'b1;
        end else begin
          isi_valid_o <= 1'b0;
        end
      end else begin
        isi_valid_o <= 1'b0;
        if (gap != CNT_MAX) begin
          gap <= gap + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Converts a binary spike train back into numeric values. The spike train comes from the `lif` neuron's `spike_o` or from an external pad. The block is the decode end of the synapse→LIF encode path.

It produces two measurements:
- a windowed spike-rate count over a programmable number of cycles;
- an independent inter-spike-interval (ISI) measurement.

It sits beside `lif` in the top level and drives the output pins and a readout path.

## Interface

Parameters:
- `WIDTH`, default 8: width of the window length, the spike count and the ISI.

Ports:
- `clk_i`, input, 1: single clock, rising edge.
- `rst_ni`, input, 1: asynchronous, active-low reset.
- `en_i`, input, 1: run enable. Windows start and continue only while this is high.
- `spike_i`, input, 1: spike train, sampled on every rising edge.
- `window_i`, input, WIDTH: window length in cycles. A value of 0 means 2^WIDTH cycles. Latched only when a window starts.
- `rate_o`, output, WIDTH: spike count of the last completed window.
- `rate_valid_o`, output, 1: one-cycle pulse, high when `rate_o` has just been updated.
- `sat_o`, output, 1: the spike count saturated in the window reported on `rate_o`.
- `isi_o`, output, WIDTH: cycles between the last two spikes.
- `isi_valid_o`, output, 1: one-cycle pulse, high when `isi_o` has just been updated.
- `busy_o`, output, 1: high whenever the FSM is not in IDLE.

## Operation

Rate FSM states: IDLE, ACCUM, REPORT.
- **IDLE**
  - Window counter and spike counter are held at 0.
  - On an edge with `en_i`=1: latch `window_i` as N (0 → 2^WIDTH), clear both counters, go to ACCUM.
- **ACCUM**
  - On each edge: if `spike_i`=1, the spike counter increments, saturating at 2^WIDTH−1.
  - A spike that arrives while the counter is already at max sets an internal sat flag.
  - The window counter increments on each edge. It is WIDTH+1 bits wide so that N=2^WIDTH can be reached.
  - On the edge that completes the N-th ACCUM cycle (that cycle's spike included): `rate_o` ← count, `sat_o` ← sat flag, `rate_valid_o` ← 1, go to REPORT.
  - `en_i`=0 on any ACCUM edge aborts the window:
    - go to IDLE and clear the counters;
    - `rate_o` and `sat_o` hold their previous values;
    - no valid pulse.
- **REPORT** (exactly one cycle)
  - `rate_valid_o` is high for this cycle.
  - `spike_i` is ignored for rate purposes in this cycle (a dead cycle between windows).
  - On the next edge: if `en_i`=1, latch a new `window_i`, clear the counters, go to ACCUM. Otherwise go to IDLE.
  - `rate_valid_o` returns to 0 on that edge in either case.
- `busy_o` = (state ≠ IDLE), taken directly from the state register.

ISI tracker (independent of the FSM and of `en_i`; runs continuously after reset):
- Internal state:
  - gap counter `g`, WIDTH bits, reset value 0;
  - `seen` flag, reset value 0.
- Edge with `spike_i`=1 and `seen`=1: `isi_o` ← `g`, `isi_valid_o` ← 1, `g` ← 1.
- Edge with `spike_i`=1 and `seen`=0: `seen` ← 1, `g` ← 1, no valid pulse.
- Edge with `spike_i`=0: `g` ← `g`+1, saturating at 2^WIDTH−1, so `isi_o`=max means ≥ max. `isi_valid_o` ← 0.
- Spikes on consecutive cycles give `isi_o`=1.

Arithmetic: all counters are unsigned and saturating. Nothing wraps.

## Timing

- Reset (asynchronous, immediate):
  - FSM → IDLE;
  - `rate_o`=0, `rate_valid_o`=0, `sat_o`=0, `isi_o`=0, `isi_valid_o`=0, `busy_o`=0;
  - `g`=0, `seen`=0.
- Reset asserted mid-window discards the window with no valid pulse. Operation restarts from IDLE after release.
- Let E0 be the edge that samples `en_i`=1 in IDLE.
  - ACCUM samples `spike_i` on edges E1..EN.
  - `rate_valid_o` is high during the cycle after EN.
- Continuous `en_i` gives a window period of N+1 cycles: N counted cycles plus 1 REPORT dead cycle.
- `isi_valid_o` rises in the cycle after the edge that sampled the spike. Pulses can be back-to-back.
- `rate_valid_o` and `isi_valid_o` can be high in the same cycle; they are independent.
- Changes to `window_i` outside a window-start edge have no effect.

## Test plan

1. **Reset.** Apply reset, then hold `rst_ni`=0 with random `spike_i`/`en_i`.
   - Required: all outputs 0.
   - Required: assert `rst_ni` mid-ACCUM → outputs clear immediately and no `rate_valid_o` follows.
2. **Nominal window.** `window_i`=10, `en_i` held 1, `spike_i` high on alternate edges E1,E3,…,E9.
   - Required: `rate_o`=5, `sat_o`=0, `rate_valid_o` high for one cycle after E10.
   - Required: the next pulse arrives exactly 11 cycles later.
   - Required: a spike in the REPORT cycle is not counted.
3. **Saturation.** `window_i`=0, `spike_i` held 1.
   - Required: `rate_valid_o` after 256 ACCUM cycles with `rate_o`=255, `sat_o`=1.
   - Required: the next window with no spikes reports `rate_o`=0, `sat_o`=0.
4. **Abort.** `window_i`=20, drop `en_i` at cycle 7 of ACCUM.
   - Required: no `rate_valid_o`, `busy_o` falls one cycle later, `rate_o` and `sat_o` unchanged.
   - Required: re-enable starts a fresh 20-cycle window with a count of 0.
5. **ISI.** After reset, spikes at cycles 0, 1, 4, then a spike at cycle 304.
   - Required: no pulse for cycle 0.
   - Required: `isi_valid_o` pulses with `isi_o` = 1, then 3, then 255 (saturated).
6. **Window reload.** Change `window_i` 4→6 during ACCUM with `en_i` held.
   - Required: the current window stays 4 cycles; the next window is 6 cycles.
